// File: rtl/unified_mem_arbiter_if.sv
// Hart-side fetch/data ports, memory-macro port and perf counters of the unified memory arbiter.
// The master modport is the hart plus the memory model. The slave modport is the arbiter.
interface unified_mem_arbiter_if #(
    parameter int CNT_W = 32
);
    // Instruction-fetch port
    logic             i_if_req;
    logic [31:0]      i_if_addr;
    logic             o_if_gnt;
    logic             o_if_rvalid;
    logic [31:0]      o_if_rdata;

    // Data port
    logic             i_d_req;
    logic             i_d_wen;
    logic [31:0]      i_d_addr;
    logic [31:0]      i_d_wdata;
    logic [3:0]       i_d_mask;
    logic             o_d_gnt;
    logic             o_d_rvalid;
    logic [31:0]      o_d_rdata;

    // Memory macro
    logic             o_mem_en;
    logic             o_mem_wen;
    logic [31:0]      o_mem_addr;
    logic [31:0]      o_mem_wdata;
    logic [3:0]       o_mem_mask;
    logic [31:0]      i_mem_rdata;

    // Perf counters
    logic [CNT_W-1:0] o_if_stall_cnt;
    logic [CNT_W-1:0] o_d_stall_cnt;

    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_gnt, o_if_rvalid, o_if_rdata,
        input  i_d_req, i_d_wen, i_d_addr, i_d_wdata, i_d_mask,
        output o_d_gnt, o_d_rvalid, o_d_rdata,
        output o_mem_en, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask,
        input  i_mem_rdata,
        output o_if_stall_cnt, o_d_stall_cnt
    );

    modport master (
        output i_if_req, i_if_addr,
        input  o_if_gnt, o_if_rvalid, o_if_rdata,
        output i_d_req, i_d_wen, i_d_addr, i_d_wdata, i_d_mask,
        input  o_d_gnt, o_d_rvalid, o_d_rdata,
        input  o_mem_en, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask,
        output i_mem_rdata,
        input  o_if_stall_cnt, o_d_stall_cnt
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Unified memory arbiter. One single-ported synchronous memory is shared by the fetch port and the data port.
// Data requests win by default. After STARVE_LIMIT consecutive denials, fetch is forced through.
// Read data returns one cycle after the grant and is routed to the port that owns the read.
module unified_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    unified_mem_arbiter_if.slave bus
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    owner_e           rd_owner_q, rd_owner_d;
    logic [3:0]       starve_q, starve_d;
    logic [CNT_W-1:0] if_stall_q, if_stall_d;
    logic [CNT_W-1:0] d_stall_q, d_stall_d;
    logic             if_gnt, d_gnt;

    // Grant decision. Data wins unless fetch has hit its starvation limit. Both grants are held off during reset.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (i_rst_n) begin
            if (bus.i_if_req && (!bus.i_d_req || starve_q == STARVE_MAX)) begin
                if_gnt = 1'b1;
            end else if (bus.i_d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    assign bus.o_if_gnt = if_gnt;
    assign bus.o_d_gnt  = d_gnt;

    // Memory port mux. A fetch is always a full-word read. An idle cycle drives all zeros.
    always_comb begin
        bus.o_mem_en    = 1'b0;
        bus.o_mem_wen   = 1'b0;
        bus.o_mem_addr  = 32'h0;
        bus.o_mem_wdata = 32'h0;
        bus.o_mem_mask  = 4'h0;
        if (if_gnt) begin
            bus.o_mem_en   = 1'b1;
            bus.o_mem_addr = bus.i_if_addr;
            bus.o_mem_mask = 4'hF;
        end else if (d_gnt) begin
            bus.o_mem_en    = 1'b1;
            bus.o_mem_wen   = bus.i_d_wen;
            bus.o_mem_addr  = bus.i_d_addr;
            bus.o_mem_wdata = bus.i_d_wdata;
            bus.o_mem_mask  = bus.i_d_mask;
        end
    end

    // Next state for the starvation count and the saturating stall counters.
    always_comb begin
        starve_d   = starve_q;
        if_stall_d = if_stall_q;
        d_stall_d  = d_stall_q;
        if (!bus.i_if_req || if_gnt) begin
            starve_d = 4'd0;
        end else if (starve_q < STARVE_MAX) begin
            starve_d = starve_q + 4'd1;
        end
        if (bus.i_if_req && !if_gnt && if_stall_q != {CNT_W{1'b1}}) begin
            if_stall_d = if_stall_q + CNT_W'(1);
        end
        if (bus.i_d_req && !d_gnt && d_stall_q != {CNT_W{1'b1}}) begin
            d_stall_d = d_stall_q + CNT_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            starve_q   <= 4'd0;
            if_stall_q <= '0;
            d_stall_q  <= '0;
        end else begin
            starve_q   <= starve_d;
            if_stall_q <= if_stall_d;
            d_stall_q  <= d_stall_d;
        end
    end

    assign bus.o_if_stall_cnt = if_stall_q;
    assign bus.o_d_stall_cnt  = d_stall_q;

    // Read-owner state register. Reset drops any read that is in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_owner_q <= OWN_NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    // Read-owner next state. Only reads that were granted this cycle produce a response next cycle.
    always_comb begin
        rd_owner_d = OWN_NONE;
        if (if_gnt) begin
            rd_owner_d = OWN_IF;
        end else if (d_gnt && !bus.i_d_wen) begin
            rd_owner_d = OWN_D;
        end
    end

    // Read response routing. The port that does not own the read sees zero data.
    always_comb begin
        bus.o_if_rvalid = (rd_owner_q == OWN_IF);
        bus.o_d_rvalid  = (rd_owner_q == OWN_D);
        bus.o_if_rdata  = (rd_owner_q == OWN_IF) ? bus.i_mem_rdata : 32'h0;
        bus.o_d_rdata   = (rd_owner_q == OWN_D)  ? bus.i_mem_rdata : 32'h0;
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter. Read responses are checked by a queue-based scoreboard.
module tb_unified_mem_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.CNT_W(32)) bus ();
    unified_mem_arbiter_if #(.CNT_W(4))  bus2 ();

    unified_mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
    );
    unified_mem_arbiter #(.STARVE_LIMIT(15), .CNT_W(4)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus2)
    );

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Fixed memory contents, independent of the DUT.
    function automatic logic [31:0] lookup(input logic [31:0] a);
        case (a)
            32'h10:  return 32'hDEADBEEF;
            32'h40:  return 32'hA5A5A5A5;
            32'h44:  return 32'h00000013;
            default: return ~a;
        endcase
    endfunction

    // Synchronous single-port memory model: read data one cycle after the access.
    always @(posedge clk) begin
        if (!rst_n) bus.i_mem_rdata <= 32'h0;
        else if (bus.o_mem_en && !bus.o_mem_wen) bus.i_mem_rdata <= lookup(bus.o_mem_addr);
    end
    assign bus2.i_mem_rdata = 32'h0;

    // Monitor: every queued response is due on the very next falling edge.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.o_if_rvalid && bus.o_d_rvalid) chk("both_rvalid", 1, 0);
                if (bus.o_if_rvalid || bus.o_d_rvalid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rvalid", {bus.o_if_rvalid, bus.o_d_rvalid}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_port_is_d", bus.o_d_rvalid, e.is_d);
                        chk("rsp_data", e.is_d ? bus.o_d_rdata : bus.o_if_rdata, e.data);
                        chk("rsp_other_zero", e.is_d ? bus.o_if_rdata : bus.o_d_rdata, 0);
                    end
                end else if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("missing_rvalid", 0, 1);
                end
            end
        end
    end

    // One request cycle with the expected grant, the expected memory drive and the expected response.
    task automatic drive(input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dw, input logic [31:0] da,
                         input logic [31:0] dwd, input logic [3:0] dm,
                         input logic eig, input logic edg, input logic [31:0] erd,
                         input logic push_en, input string tag);
        rsp_t r;
        @(negedge clk);
        bus.i_if_req  = ir;  bus.i_if_addr = ia;
        bus.i_d_req   = dr;  bus.i_d_wen   = dw;  bus.i_d_addr = da;
        bus.i_d_wdata = dwd; bus.i_d_mask  = dm;
        #1;
        chk({tag, ".if_gnt"}, bus.o_if_gnt, eig);
        chk({tag, ".d_gnt"},  bus.o_d_gnt,  edg);
        chk({tag, ".mem_en"},  bus.o_mem_en, eig | edg);
        chk({tag, ".mem_wen"}, bus.o_mem_wen, edg & dw);
        chk({tag, ".mem_addr"}, bus.o_mem_addr, eig ? ia : (edg ? da : 32'h0));
        chk({tag, ".mem_mask"}, bus.o_mem_mask, eig ? 4'hF : (edg ? dm : 4'h0));
        chk({tag, ".mem_wdata"}, bus.o_mem_wdata, edg ? dwd : 32'h0);
        if (push_en && eig) begin
            r.is_d = 1'b0; r.data = erd; exp_q.push_back(r);
        end else if (push_en && edg && !dw) begin
            r.is_d = 1'b1; r.data = erd; exp_q.push_back(r);
        end
    endtask

    task automatic idle(input string tag);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int denied;
        logic [3:0] exp_cnt;

        // Reset state, with both ports requesting.
        bus.i_if_req = 1; bus.i_if_addr = 32'h10;
        bus.i_d_req = 1; bus.i_d_wen = 0; bus.i_d_addr = 32'h40;
        bus.i_d_wdata = 0; bus.i_d_mask = 4'hF;
        bus2.i_if_req = 0; bus2.i_if_addr = 0; bus2.i_d_req = 0; bus2.i_d_wen = 1;
        bus2.i_d_addr = 32'h80; bus2.i_d_wdata = 0; bus2.i_d_mask = 0;
        #12;
        chk("rst.if_gnt", bus.o_if_gnt, 0);
        chk("rst.d_gnt", bus.o_d_gnt, 0);
        chk("rst.mem_en", bus.o_mem_en, 0);
        chk("rst.if_rvalid", bus.o_if_rvalid, 0);
        chk("rst.d_rvalid", bus.o_d_rvalid, 0);
        chk("rst.if_rdata", bus.o_if_rdata, 0);
        chk("rst.d_rdata", bus.o_d_rdata, 0);
        chk("rst.if_stall", bus.o_if_stall_cnt, 0);
        chk("rst.d_stall", bus.o_d_stall_cnt, 0);
        @(negedge clk);
        bus.i_if_req = 0; bus.i_d_req = 0;
        rst_n = 1'b1;

        // Fetch-only read.
        drive(1, 32'h10, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 1, "t1");
        idle("t1.idle");

        // Data write: no response.
        drive(0, 0, 1, 1, 32'h20, 32'h11223344, 4'b0011, 0, 1, 0, 1, "t3");
        idle("t3.idle");
        idle("t3.idle2");

        // Back-to-back data read then fetch read.
        drive(0, 0, 1, 0, 32'h40, 0, 4'hF, 0, 1, 32'hA5A5A5A5, 1, "t4.d");
        drive(1, 32'h44, 0, 0, 0, 0, 0, 1, 0, 32'h00000013, 1, "t4.if");
        idle("t4.idle");
        chk("t4.if_stall", bus.o_if_stall_cnt, 0);
        chk("t4.d_stall", bus.o_d_stall_cnt, 0);

        // Both ports requesting continuously: D,D,D,D,IF repeating.
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4)
                drive(1, 32'h44, 1, 0, 32'h40, 0, 4'hF, 1, 0, 32'h00000013, 1, "t2.if");
            else
                drive(1, 32'h44, 1, 0, 32'h40, 0, 4'hF, 0, 1, 32'hA5A5A5A5, 1, "t2.d");
            if (k == 4) begin
                @(posedge clk); #1;
                chk("t2.if_stall_5", bus.o_if_stall_cnt, 4);
                chk("t2.d_stall_5", bus.o_d_stall_cnt, 1);
            end
        end
        @(posedge clk); #1;
        chk("t2.if_stall_10", bus.o_if_stall_cnt, 8);
        chk("t2.d_stall_10", bus.o_d_stall_cnt, 2);

        // Reset while a data read is in flight: the response is dropped.
        drive(0, 0, 1, 0, 32'h40, 0, 4'hF, 0, 1, 0, 0, "t5");
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t5.d_rvalid", bus.o_d_rvalid, 0);
        chk("t5.if_stall", bus.o_if_stall_cnt, 0);
        chk("t5.d_stall", bus.o_d_stall_cnt, 0);
        bus.i_if_req = 1; bus.i_d_req = 1;
        #1;
        chk("t5.if_gnt", bus.o_if_gnt, 0);
        chk("t5.d_gnt", bus.o_d_gnt, 0);
        chk("t5.mem_en", bus.o_mem_en, 0);
        @(negedge clk);
        bus.i_if_req = 0; bus.i_d_req = 0;
        rst_n = 1'b1;
        idle("t5.idle");
        idle("t5.idle2");

        // Narrow counter saturates. Fetch is dropped once to keep it from being forced through.
        denied = 0;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            bus2.i_if_req = (i != 10);
            bus2.i_d_req  = 1'b1;
            #1;
            chk("t6.if_gnt", bus2.o_if_gnt, 0);
            chk("t6.d_gnt", bus2.o_d_gnt, 1);
            if (i != 10) denied++;
            @(posedge clk); #1;
            exp_cnt = (denied > 15) ? 4'hF : 4'(denied);
            chk("t6.if_stall", bus2.o_if_stall_cnt, exp_cnt);
        end
        chk("t6.if_stall_final", bus2.o_if_stall_cnt, 4'hF);
        chk("t6.d_stall", bus2.o_d_stall_cnt, 0);
        @(negedge clk);
        bus2.i_if_req = 0; bus2.i_d_req = 0;

        @(negedge clk); #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
